// File: rtl/lsq_multi_forward_if.sv
// lsq_multi_forward_if: issue, writeback and memory-side signal bundle for lsq_multi_forward
interface lsq_multi_forward_if #(parameter int ID_W = 3);
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [31:0]     issue_addr;
  logic            issue_load;
  logic            issue_store;
  logic [3:0]      issue_be;
  logic [2:0]      issue_fn3;
  logic [31:0]     issue_data;
  logic            issue_fwd;
  logic [ID_W-1:0] issue_data_id;
  logic            wb_valid;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [ID_W-1:0] out_id;
  logic [31:0]     out_addr;
  logic            out_load;
  logic            out_store;
  logic [3:0]      out_be;
  logic [2:0]      out_fn3;
  logic [31:0]     out_data;
  modport master (
    output flush, issue_valid, issue_id, issue_addr, issue_load, issue_store, issue_be,
           issue_fn3, issue_data, issue_fwd, issue_data_id, wb_valid, wb_id, wb_data, out_ready,
    input  issue_ready, out_valid, out_id, out_addr, out_load, out_store, out_be, out_fn3, out_data
  );
  modport slave (
    input  flush, issue_valid, issue_id, issue_addr, issue_load, issue_store, issue_be,
           issue_fn3, issue_data, issue_fwd, issue_data_id, wb_valid, wb_id, wb_data, out_ready,
    output issue_ready, out_valid, out_id, out_addr, out_load, out_store, out_be, out_fn3, out_data
  );
endinterface

// File: rtl/lsq_multi_forward.sv
// lsq_multi_forward: in-order load/store queue with multiple forwarded-store data slots.
// Define LSQ_MISALIGN_CHECK_EN to build the misalign_err check.
module lsq_multi_forward #(
  parameter int DEPTH = 8,
  parameter int ID_W = 3,
  parameter int FWD_SLOTS = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int SW = FWD_SLOTS > 1 ? $clog2(FWD_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  lsq_multi_forward_if.slave lsq,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               misalign_err
);
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic            load;
    logic            store;
    logic [3:0]      be;
    logic [2:0]      fn3;
    logic [31:0]     data;
    logic            fwd;
  } entry_t;
  typedef enum logic [1:0] {FREE, WAITING, READY} slot_st_e;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  slot_st_e        st_q [FWD_SLOTS];
  slot_st_e        st_d [FWD_SLOTS];
  logic [ID_W-1:0] sid_q [FWD_SLOTS];
  logic [ID_W-1:0] sid_d [FWD_SLOTS];
  logic [31:0]     sdata_q [FWD_SLOTS];
  logic [31:0]     sdata_d [FWD_SLOTS];
  logic [PW-1:0]   sidx_q [FWD_SLOTS];
  logic [PW-1:0]   sidx_d [FWD_SLOTS];
  entry_t          head;
  logic            free_any, head_rdy, push, pop;
  logic [SW-1:0]   free_sel;
  logic [31:0]     head_fdata, src;
  logic [1:0]      a;
  always_comb begin
    free_any = 1'b0;
    free_sel = '0;
    head_rdy = 1'b0;
    head_fdata = '0;
    for (int s = FWD_SLOTS - 1; s >= 0; s--) begin
      if (st_q[s] == FREE) begin
        free_any = 1'b1;
        free_sel = SW'(s);
      end
      if (st_q[s] == READY && sidx_q[s] == head_q) begin
        head_rdy = 1'b1;
        head_fdata = sdata_q[s];
      end
    end
  end
  assign head            = mem_q[head_q];
  assign count           = count_q;
  assign empty           = count_q == '0;
  assign lsq.issue_ready = count_q < CW'(DEPTH) && (!lsq.issue_fwd || free_any);
  assign lsq.out_valid   = !empty && (!head.fwd || head_rdy);
  assign push            = lsq.issue_valid & lsq.issue_ready;
  assign pop             = lsq.out_valid & lsq.out_ready;
  assign lsq.out_id      = head.id;
  assign lsq.out_addr    = head.addr;
  assign lsq.out_load    = head.load;
  assign lsq.out_store   = head.store;
  assign lsq.out_be      = head.be;
  assign lsq.out_fn3     = head.fn3;
  assign src             = head.fwd ? head_fdata : head.data;
  assign a               = head.addr[1:0];
  // Replicate the low byte/halfword into the lanes selected by the address offset
  assign lsq.out_data = {a == 2'b10 ? src[15:8] : a == 2'b11 ? src[7:0] : src[31:24],
                         a == 2'b10 ? src[7:0] : src[23:16],
                         a == 2'b01 ? src[7:0] : src[15:8],
                         src[7:0]};
`ifdef LSQ_MISALIGN_CHECK_EN
  assign misalign_err = lsq.out_valid & ((head.fn3[1:0] == 2'b01 & head.addr[0]) |
                                         (head.fn3[1:0] == 2'b10 & |head.addr[1:0]));
`else
  assign misalign_err = 1'b0;
`endif
  always_comb begin
    mem_d = mem_q;
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    st_d = st_q;
    sid_d = sid_q;
    sdata_d = sdata_q;
    sidx_d = sidx_q;
    if (push)
      mem_d[tail_q] = '{id: lsq.issue_id, addr: lsq.issue_addr, load: lsq.issue_load,
                        store: lsq.issue_store, be: lsq.issue_be, fn3: lsq.issue_fn3,
                        data: lsq.issue_data, fwd: lsq.issue_fwd};
    for (int s = 0; s < FWD_SLOTS; s++) begin
      if (st_q[s] == WAITING && lsq.wb_valid && lsq.wb_id == sid_q[s]) begin
        st_d[s] = READY;
        sdata_d[s] = lsq.wb_data;
      end
      if (pop && st_q[s] != FREE && sidx_q[s] == head_q) st_d[s] = FREE;
    end
    // A same-cycle matching writeback lets a new forwarded store skip WAITING
    if (push && lsq.issue_fwd) begin
      st_d[free_sel] = lsq.wb_valid && lsq.wb_id == lsq.issue_data_id ? READY : WAITING;
      sid_d[free_sel] = lsq.issue_data_id;
      sdata_d[free_sel] = lsq.wb_data;
      sidx_d[free_sel] = tail_q;
    end
    if (lsq.flush) begin
      head_d = '0;
      tail_d = '0;
      count_d = '0;
      for (int s = 0; s < FWD_SLOTS; s++) st_d[s] = FREE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int s = 0; s < FWD_SLOTS; s++) st_q[s] <= FREE;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      st_q <= st_d;
    end
    mem_q <= mem_d;
    sid_q <= sid_d;
    sdata_q <= sdata_d;
    sidx_q <= sidx_d;
  end
endmodule

// File: tb/tb_lsq_multi_forward.sv
// tb_lsq_multi_forward: randomized and directed checks of lsq_multi_forward against a queue-based model
module tb_lsq_multi_forward;
  localparam int DEPTH = 8;
  localparam int FWD_SLOTS = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count;
  logic       empty, misalign_err;
  int         n_cmp = 0;
  int         n_bad = 0;
  typedef struct {
    logic [2:0]  id;
    logic [31:0] addr;
    logic        ld, st;
    logic [3:0]  be;
    logic [2:0]  fn3;
    logic [31:0] data;
    logic        fwd;
    logic [2:0]  did;
    logic        have;
    logic [31:0] fdata;
  } req_t;
  req_t q[$];
  lsq_multi_forward_if #(.ID_W(3)) bus ();
  lsq_multi_forward #(.DEPTH(DEPTH), .ID_W(3), .FWD_SLOTS(FWD_SLOTS)) dut (
    .clk(clk), .rst(rst), .lsq(bus), .count(count), .empty(empty), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
  function automatic logic [31:0] align(logic [31:0] d, logic [1:0] a);
    case (a)
      2'd0: return d;
      2'd1: return {d[31:16], d[7:0], d[7:0]};
      2'd2: return {d[15:0], d[15:0]};
      default: return {d[7:0], d[23:16], d[15:8], d[7:0]};
    endcase
  endfunction
  function automatic logic exp_mis(logic v, logic [2:0] fn3, logic [31:0] addr);
`ifdef LSQ_MISALIGN_CHECK_EN
    return v && ((fn3[1:0] == 2'd1 && addr[0]) || (fn3[1:0] == 2'd2 && addr[1:0] != 2'd0));
`else
    return 1'b0;
`endif
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle();
    bus.flush = 0; bus.issue_valid = 0; bus.issue_id = 0; bus.issue_addr = 0;
    bus.issue_load = 0; bus.issue_store = 0; bus.issue_be = 0; bus.issue_fn3 = 0;
    bus.issue_data = 0; bus.issue_fwd = 0; bus.issue_data_id = 0;
    bus.wb_valid = 0; bus.wb_id = 0; bus.wb_data = 0; bus.out_ready = 0;
  endtask
  task automatic issue(logic [2:0] id, logic [31:0] addr, logic st, logic [2:0] fn3,
                       logic [31:0] data, logic fwd, logic [2:0] did);
    bus.issue_valid = 1; bus.issue_id = id; bus.issue_addr = addr;
    bus.issue_load = !st; bus.issue_store = st; bus.issue_fn3 = fn3;
    bus.issue_be = fn3[1:0] == 2'd0 ? 4'h1 : fn3[1:0] == 2'd1 ? 4'h3 : 4'hF;
    bus.issue_data = data; bus.issue_fwd = fwd; bus.issue_data_id = did;
  endtask
  task automatic wb(logic [2:0] id, logic [31:0] data);
    bus.wb_valid = 1; bus.wb_id = id; bus.wb_data = data;
  endtask
  // Compare outputs with the model for the inputs now applied, then advance the model one clock
  task automatic cycle();
    req_t r;
    int   fw;
    logic er, ev;
    #1;
    fw = 0;
    foreach (q[i]) if (q[i].fwd) fw++;
    er = q.size() < DEPTH && (!bus.issue_fwd || fw < FWD_SLOTS);
    ev = q.size() > 0 && (!q[0].fwd || q[0].have);
    chk("issue_ready", 32'(bus.issue_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    if (ev) begin
      chk("misalign_err", 32'(misalign_err), 32'(exp_mis(1'b1, q[0].fn3, q[0].addr)));
      chk("out_id", 32'(bus.out_id), 32'(q[0].id));
      chk("out_addr", bus.out_addr, q[0].addr);
      chk("out_load", 32'(bus.out_load), 32'(q[0].ld));
      chk("out_store", 32'(bus.out_store), 32'(q[0].st));
      chk("out_be", 32'(bus.out_be), 32'(q[0].be));
      chk("out_fn3", 32'(bus.out_fn3), 32'(q[0].fn3));
      chk("out_data", bus.out_data, align(q[0].fwd ? q[0].fdata : q[0].data, q[0].addr[1:0]));
    end else chk("misalign_err", 32'(misalign_err), 32'd0);
    if (bus.flush) q.delete();
    else begin
      foreach (q[i])
        if (q[i].fwd && !q[i].have && bus.wb_valid && bus.wb_id == q[i].did) begin
          q[i].have = 1;
          q[i].fdata = bus.wb_data;
        end
      if (ev && bus.out_ready) void'(q.pop_front());
      if (bus.issue_valid && er) begin
        r = '{bus.issue_id, bus.issue_addr, bus.issue_load, bus.issue_store, bus.issue_be,
              bus.issue_fn3, bus.issue_data, bus.issue_fwd, bus.issue_data_id,
              bus.issue_fwd && bus.wb_valid && bus.wb_id == bus.issue_data_id, bus.wb_data};
        q.push_back(r);
      end
    end
    @(negedge clk);
  endtask
  initial begin
    int fl[5] = '{0, 1, 2, 4, 5};
    idle();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    // Byte stores at three offsets, then drain in order
    idle(); issue(3'd1, 32'h100, 1, 3'd0, 32'hAB, 0, 0); cycle();
    idle(); #1 chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    issue(3'd2, 32'h101, 1, 3'd0, 32'hAB, 0, 0); cycle();
    idle(); issue(3'd3, 32'h102, 1, 3'd0, 32'hAB, 0, 0); cycle();
    idle(); bus.out_ready = 1; #1;
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_d0", bus.out_data, 32'h000000AB); cycle();
    chk("t1_d1", bus.out_data, 32'h0000ABAB); cycle();
    chk("t1_d2", bus.out_data, 32'h00AB00AB); cycle();
    chk("t1_empty", 32'(empty), 32'd1);
    // Fill to DEPTH, then push+pop at full
    for (int i = 0; i < DEPTH; i++) begin
      idle(); issue(3'(i), 32'h400 + 32'(4 * i), 0, 3'd2, 0, 0, 0); cycle();
    end
    idle(); issue(3'd0, 32'h500, 0, 3'd2, 0, 0, 0); bus.out_ready = 1; #1;
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(bus.issue_ready), 32'd0);
    cycle();
    idle(); #1 chk("full_pop_count", 32'(count), 32'd7);
    bus.flush = 1; cycle();
    // Two forwarded stores resolved out of order
    idle(); issue(3'd1, 32'h200, 1, 3'd2, 0, 1, 3'd5); cycle();
    idle(); issue(3'd2, 32'h204, 1, 3'd2, 0, 1, 3'd6); cycle();
    idle(); wb(3'd6, 32'h66666666); bus.out_ready = 1; #1;
    chk("fwd_wait", 32'(bus.out_valid), 32'd0); cycle();
    idle(); wb(3'd5, 32'h55555555); bus.out_ready = 1; #1;
    chk("fwd_wait2", 32'(bus.out_valid), 32'd0); cycle();
    idle(); bus.out_ready = 1; #1;
    chk("fwd_v0", 32'(bus.out_valid), 32'd1);
    chk("fwd_d0", bus.out_data, 32'h55555555); cycle();
    chk("fwd_v1", 32'(bus.out_valid), 32'd1);
    chk("fwd_d1", bus.out_data, 32'h66666666); cycle();
    // Forwarded push with same-cycle writeback
    idle(); issue(3'd7, 32'h300, 1, 3'd2, 0, 1, 3'd3); wb(3'd3, 32'hDEADBEEF); cycle();
    idle(); #1;
    chk("same_wb_v", 32'(bus.out_valid), 32'd1);
    chk("same_wb_d", bus.out_data, 32'hDEADBEEF);
    bus.out_ready = 1; cycle();
    // Slots exhausted: forwarded issue refused, plain issue accepted
    idle(); issue(3'd1, 32'h10, 1, 3'd2, 0, 1, 3'd4); cycle();
    idle(); issue(3'd2, 32'h14, 1, 3'd2, 0, 1, 3'd4); cycle();
    idle(); issue(3'd3, 32'h18, 1, 3'd2, 0, 1, 3'd1); #1;
    chk("slots_full_fwd", 32'(bus.issue_ready), 32'd0);
    bus.issue_fwd = 0; #1;
    chk("slots_full_plain", 32'(bus.issue_ready), 32'd1);
    cycle();
    idle(); wb(3'd4, 32'h44444444); cycle();
    idle(); bus.out_ready = 1; #1;
    chk("multi_wb_d0", bus.out_data, 32'h44444444); cycle();
    chk("multi_wb_d1", bus.out_data, 32'h44444444); cycle();
    cycle();
    // Flush with a waiting slot; a stale writeback must not revive it
    for (int i = 0; i < 3; i++) begin
      idle(); issue(3'(i), 32'h600 + 32'(i), 0, 3'd0, 0, 0, 0); cycle();
    end
    idle(); issue(3'd3, 32'h700, 1, 3'd2, 0, 1, 3'd2); cycle();
    idle(); bus.flush = 1; cycle();
    idle(); #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    wb(3'd2, 32'h22222222); cycle();
    idle(); issue(3'd4, 32'h704, 1, 3'd2, 0, 1, 3'd2); cycle();
    idle(); #1 chk("flush_stale_wb", 32'(bus.out_valid), 32'd0);
    issue(3'd5, 32'h708, 1, 3'd2, 0, 1, 3'd0); #1;
    chk("flush_slot_free", 32'(bus.issue_ready), 32'd1);
    cycle();
    idle(); bus.flush = 1; cycle();
    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      bus.flush = $urandom_range(0, 59) == 0;
      bus.out_ready = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 9) < 6)
        issue(3'($urandom), $urandom, 1'($urandom), 3'(fl[$urandom_range(0, 4)]), $urandom,
              $urandom_range(0, 9) < 3, 3'($urandom));
      bus.issue_be = 4'($urandom);
      bus.wb_valid = 1'($urandom);
      bus.wb_id = 3'($urandom);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) bus.wb_id = q[$urandom_range(0, q.size() - 1)].did;
      bus.wb_data = $urandom;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
